load_use_scoreboard: RTL and testbench

- Parametrised successor to the single-cycle load-use stall check in the ID stage.
- Tracks every in-flight load destination for LOAD_LAT cycles after it leaves ID, instead of only the load sitting in EX. This supports multi-cycle data memory and deeper back-ends.
- Drives the ID/IF stall (PC and IF/ID hold, ID/EX bubble) and exposes a stall-cycle counter for performance analysis.

---
 rtl/load_use_scoreboard.sv | 118 +++++++++++
 tb/tb_load_use_scoreboard.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_use_scoreboard.sv
// ---------------------------------------------------------------------------
// load_use_scoreboard
//
// Load-use hazard detector for the ID stage. It keeps a short shift line of
// in-flight load destinations, LOAD_LAT slots deep. Slot 0 holds the
// instruction that most recently left ID. While any valid slot holds a
// register that the instruction in ID reads, the block requests a stall.
// The stall holds the PC and IF/ID, and inserts an ID/EX bubble.
//
// Optional feature macro: LOAD_USE_STALL_CNT_EN
//   defined   -> stall_cnt counts cycles with stall=1 and hold=0 (wraps)
//   undefined -> stall_cnt is tied to 0 and has no flops
//
// Ports:
//   clk         in   pipeline clock, rising edge
//   rst_n       in   synchronous active-low reset
//   rs1_id      in   ID source register 1
//   rs2_id      in   ID source register 2
//   use_rs1_id  in   ID instruction reads rs1
//   use_rs2_id  in   ID instruction reads rs2
//   rd_id       in   ID destination register
//   memread_id  in   ID instruction is a load
//   valid_id    in   ID holds a real instruction
//   hold        in   global freeze; scoreboard does not advance
//   flush       in   kills the instruction in ID
//   stall       out  combinational stall request
//   hazard_age  out  slot index of the youngest matching load (0 if no stall)
//   stall_cnt   out  stall-cycle counter (optional feature)
// ---------------------------------------------------------------------------
module load_use_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              use_rs1_id,
    input  logic              use_rs2_id,
    input  logic [REG_AW-1:0] rd_id,
    input  logic              memread_id,
    input  logic              valid_id,
    input  logic              hold,
    input  logic              flush,
    output logic              stall,
    output logic [2:0]        hazard_age,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [LOAD_LAT-1:0] slot_v;
    logic [REG_AW-1:0]   slot_rd [LOAD_LAT];

    logic       match1;
    logic       match2;
    logic [2:0] match_age;

    // Compare both sources against every slot. The scan runs from the oldest
    // slot down to slot 0, so the last hit written is the youngest load. That
    // is the one the consumer must actually wait for.
    always_comb begin
        match1    = 1'b0;
        match2    = 1'b0;
        match_age = 3'd0;
        for (int k = LOAD_LAT - 1; k >= 0; k--) begin
            if (use_rs1_id && (rs1_id != '0) && slot_v[k] && (slot_rd[k] == rs1_id)) begin
                match1    = 1'b1;
                match_age = 3'(k);
            end
            if (use_rs2_id && (rs2_id != '0) && slot_v[k] && (slot_rd[k] == rs2_id)) begin
                match2    = 1'b1;
                match_age = 3'(k);
            end
        end
    end

    // A flushed instruction is dead. It never stalls.
    assign stall      = valid_id & ~flush & (match1 | match2);
    assign hazard_age = stall ? match_age : 3'd0;

    // Shift line of in-flight loads. A stalled or flushed instruction enters
    // slot 0 as a bubble, and the older slots keep advancing. Because of
    // this, every stall drains within LOAD_LAT cycles unless hold is set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_v <= '0;
            for (int k = 0; k < LOAD_LAT; k++) begin
                slot_rd[k] <= '0;
            end
        end else if (!hold) begin
            slot_v[0]  <= valid_id & memread_id & (rd_id != '0) & ~stall & ~flush;
            slot_rd[0] <= rd_id;
            for (int k = 1; k < LOAD_LAT; k++) begin
                slot_v[k]  <= slot_v[k-1];
                slot_rd[k] <= slot_rd[k-1];
            end
        end
    end

`ifdef LOAD_USE_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts only the stall cycles that actually cost a pipeline slot. A
    // frozen pipeline is charged to the memory system, not to the hazard.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!hold && stall) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_load_use_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_load_use_scoreboard
//
// Testbench with three scoreboard instances: LOAD_LAT = 1, 2 and 3. All three
// share one set of ID inputs. Each vector selects the instance whose outputs
// it checks. Expected values are pushed into a queue when a vector is
// applied. A monitor pops and compares on the following falling edge.
// ---------------------------------------------------------------------------
module tb_load_use_scoreboard;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       use_rs1_id;
    logic       use_rs2_id;
    logic [4:0] rd_id;
    logic       memread_id;
    logic       valid_id;
    logic       hold;
    logic       flush;

    logic        stall_l1, stall_l2, stall_l3;
    logic [2:0]  age_l1, age_l2, age_l3;
    logic [31:0] cnt_l1, cnt_l2, cnt_l3;

    typedef struct {
        int          sel;
        logic        stall;
        logic [2:0]  age;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    int   check_cnt = 0;
    int   fail_cnt  = 0;
    logic end_req   = 1'b0;

    load_use_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_id(rd_id),
        .memread_id(memread_id), .valid_id(valid_id), .hold(hold), .flush(flush),
        .stall(stall_l1), .hazard_age(age_l1), .stall_cnt(cnt_l1)
    );

    load_use_scoreboard #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(32)) dut_l2 (
        .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_id(rd_id),
        .memread_id(memread_id), .valid_id(valid_id), .hold(hold), .flush(flush),
        .stall(stall_l2), .hazard_age(age_l2), .stall_cnt(cnt_l2)
    );

    load_use_scoreboard #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(32)) dut_l3 (
        .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_id(rd_id),
        .memread_id(memread_id), .valid_id(valid_id), .hold(hold), .flush(flush),
        .stall(stall_l3), .hazard_age(age_l3), .stall_cnt(cnt_l3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The expected counter value is n when the counter feature is compiled
    // in. Otherwise it is 0.
    function automatic logic [31:0] ec(input int n);
`ifdef LOAD_USE_STALL_CNT_EN
        return 32'(n);
`else
        return (n == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // Drive one ID cycle just after the rising edge and record the expected
    // response. A negative sel means there is nothing to check in this cycle.
    task automatic applyStimulus(
        input int         sel,
        input logic       rstn_v,
        input logic       valid_v,
        input logic       mem_v,
        input logic [4:0] rd_v,
        input logic [4:0] rs1_v,
        input logic       u1_v,
        input logic [4:0] rs2_v,
        input logic       u2_v,
        input logic       hold_v,
        input logic       flush_v,
        input logic       e_stall,
        input logic [2:0] e_age,
        input logic [31:0] e_cnt,
        input string      name
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst_n      = rstn_v;
        valid_id   = valid_v;
        memread_id = mem_v;
        rd_id      = rd_v;
        rs1_id     = rs1_v;
        use_rs1_id = u1_v;
        rs2_id     = rs2_v;
        use_rs2_id = u2_v;
        hold       = hold_v;
        flush      = flush_v;
        if (sel >= 0) begin
            e.sel   = sel;
            e.stall = e_stall;
            e.age   = e_age;
            e.cnt   = e_cnt;
            e.name  = name;
            exp_q.push_back(e);
        end
    endtask

    task automatic doReset();
        applyStimulus(-1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
                      1'b0, 3'd0, 32'd0, "reset");
    endtask

    task automatic checkOutput(input exp_t e);
        logic        a_stall;
        logic [2:0]  a_age;
        logic [31:0] a_cnt;
        case (e.sel)
            0:       begin a_stall = stall_l1; a_age = age_l1; a_cnt = cnt_l1; end
            1:       begin a_stall = stall_l2; a_age = age_l2; a_cnt = cnt_l2; end
            default: begin a_stall = stall_l3; a_age = age_l3; a_cnt = cnt_l3; end
        endcase
        check_cnt++;
        if (a_stall !== e.stall) begin
            fail_cnt++;
            $display("[TB] FAIL %s stall: got %0b expected %0b", e.name, a_stall, e.stall);
        end
        check_cnt++;
        if (a_age !== e.age) begin
            fail_cnt++;
            $display("[TB] FAIL %s hazard_age: got %0d expected %0d", e.name, a_age, e.age);
        end
        check_cnt++;
        if (a_cnt !== e.cnt) begin
            fail_cnt++;
            $display("[TB] FAIL %s stall_cnt: got %0d expected %0d", e.name, a_cnt, e.cnt);
        end
    endtask

    // The monitor compares on falling edges, away from the active edge. It
    // also prints the summary once the stimulus process asks it to finish.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end else if (end_req) begin
            $display("[TB] End of test - %0d assertions evaluated, %0d failures",
                     check_cnt, fail_cnt);
            $finish;
        end
    end

    // Argument order: sel, rst_n, valid, memread, rd, rs1, use1, rs2, use2,
    // hold, flush, exp stall, exp age, exp cnt, name.
    initial begin
        rst_n = 1'b0; valid_id = 1'b0; memread_id = 1'b0; rd_id = '0;
        rs1_id = '0; rs2_id = '0; use_rs1_id = 1'b0; use_rs2_id = 1'b0;
        hold = 1'b0; flush = 1'b0;

        // Reset state of every instance.
        doReset();
        applyStimulus(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, ec(0), "rst_l1");
        applyStimulus(1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, ec(0), "rst_l2");
        applyStimulus(2, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, ec(0), "rst_l3");

        // LOAD_LAT=1: one bubble after load x5.
        applyStimulus(0, 1, 1, 1, 5'd5, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, ec(0), "l1_load");
        applyStimulus(0, 1, 1, 0, 5'd10, 5'd5, 1, 5'd0, 0, 0, 0, 1, 3'd0, ec(0), "l1_use");
        applyStimulus(0, 1, 1, 0, 5'd10, 5'd5, 1, 5'd0, 0, 0, 0, 0, 3'd0, ec(1), "l1_rel");
        applyStimulus(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, ec(1), "l1_idle");

        // x0 destinations and unused sources never stall.
        doReset();
        applyStimulus(0, 1, 1, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, ec(0), "x0_load");
        applyStimulus(0, 1, 1, 0, 5'd1, 5'd0, 1, 5'd0, 1, 0, 0, 0, 3'd0, ec(0), "x0_use");
        applyStimulus(0, 1, 1, 1, 5'd9, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, ec(0), "x9_load");
        applyStimulus(0, 1, 1, 0, 5'd2, 5'd9, 0, 5'd1, 1, 0, 0, 0, 3'd0, ec(0), "x9_nouse");

        // LOAD_LAT=3: three-cycle stall, then two with an independent gap.
        doReset();
        applyStimulus(2, 1, 1, 1, 5'd7, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, ec(0), "l3_load");
        applyStimulus(2, 1, 1, 0, 5'd8, 5'd1, 1, 5'd7, 1, 0, 0, 1, 3'd0, ec(0), "l3_s0");
        applyStimulus(2, 1, 1, 0, 5'd8, 5'd1, 1, 5'd7, 1, 0, 0, 1, 3'd1, ec(1), "l3_s1");
        applyStimulus(2, 1, 1, 0, 5'd8, 5'd1, 1, 5'd7, 1, 0, 0, 1, 3'd2, ec(2), "l3_s2");
        applyStimulus(2, 1, 1, 0, 5'd8, 5'd1, 1, 5'd7, 1, 0, 0, 0, 3'd0, ec(3), "l3_rel");
        applyStimulus(2, 1, 1, 1, 5'd7, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, ec(3), "l3_load2");
        applyStimulus(2, 1, 1, 0, 5'd8, 5'd1, 1, 5'd0, 0, 0, 0, 0, 3'd0, ec(3), "l3_indep");
        applyStimulus(2, 1, 1, 0, 5'd8, 5'd0, 0, 5'd7, 1, 0, 0, 1, 3'd1, ec(3), "l3_g1");
        applyStimulus(2, 1, 1, 0, 5'd8, 5'd0, 0, 5'd7, 1, 0, 0, 1, 3'd2, ec(4), "l3_g2");
        applyStimulus(2, 1, 1, 0, 5'd8, 5'd0, 0, 5'd7, 1, 0, 0, 0, 3'd0, ec(5), "l3_grel");

        // A load is not compared against itself, only against older loads.
        applyStimulus(2, 1, 1, 1, 5'd12, 5'd12, 1, 5'd0, 0, 0, 0, 0, 3'd0, ec(5), "self_a");
        applyStimulus(2, 1, 1, 1, 5'd12, 5'd12, 1, 5'd0, 0, 0, 0, 1, 3'd0, ec(5), "self_b0");
        applyStimulus(2, 1, 1, 1, 5'd12, 5'd12, 1, 5'd0, 0, 0, 0, 1, 3'd1, ec(6), "self_b1");
        applyStimulus(2, 1, 1, 1, 5'd12, 5'd12, 1, 5'd0, 0, 0, 0, 1, 3'd2, ec(7), "self_b2");
        applyStimulus(2, 1, 1, 1, 5'd12, 5'd12, 1, 5'd0, 0, 0, 0, 0, 3'd0, ec(8), "self_rel");

        // LOAD_LAT=2: hold freezes slots and counter during a stall.
        doReset();
        applyStimulus(1, 1, 1, 1, 5'd3, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, ec(0), "hold_load");
        applyStimulus(1, 1, 1, 0, 5'd9, 5'd3, 1, 5'd0, 0, 0, 0, 1, 3'd0, ec(0), "hold_s0");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 1, 0, 5'd9, 5'd3, 1, 5'd0, 0, 1, 0, 1, 3'd1, ec(1), "hold_on");
        end
        applyStimulus(1, 1, 1, 0, 5'd9, 5'd3, 1, 5'd0, 0, 0, 0, 1, 3'd1, ec(1), "hold_s1");
        applyStimulus(1, 1, 1, 0, 5'd9, 5'd3, 1, 5'd0, 0, 0, 0, 0, 3'd0, ec(2), "hold_rel");

        // LOAD_LAT=2: back-to-back loads to x6 make the consumer wait for the
        // younger one.
        doReset();
        applyStimulus(1, 1, 1, 1, 5'd6, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, ec(0), "b2b_ld1");
        applyStimulus(1, 1, 1, 1, 5'd6, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, ec(0), "b2b_ld2");
        applyStimulus(1, 1, 1, 0, 5'd1, 5'd6, 1, 5'd0, 0, 0, 0, 1, 3'd0, ec(0), "b2b_s0");
        applyStimulus(1, 1, 1, 0, 5'd1, 5'd6, 1, 5'd0, 0, 0, 0, 1, 3'd1, ec(1), "b2b_s1");
        applyStimulus(1, 1, 1, 0, 5'd1, 5'd6, 1, 5'd0, 0, 0, 0, 0, 3'd0, ec(2), "b2b_rel");

        // Flush kills a load in ID, and it overrides a stall.
        doReset();
        applyStimulus(1, 1, 1, 1, 5'd4, 5'd0, 0, 5'd0, 0, 0, 1, 0, 3'd0, ec(0), "fl_load");
        applyStimulus(1, 1, 1, 0, 5'd1, 5'd4, 1, 5'd0, 0, 0, 0, 0, 3'd0, ec(0), "fl_use");
        applyStimulus(1, 1, 1, 1, 5'd4, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, ec(0), "fl_load2");
        applyStimulus(1, 1, 1, 0, 5'd1, 5'd4, 1, 5'd0, 0, 0, 1, 0, 3'd0, ec(0), "fl_kill");
        applyStimulus(1, 1, 1, 0, 5'd1, 5'd4, 1, 5'd0, 0, 0, 0, 1, 3'd1, ec(0), "fl_after");
        applyStimulus(1, 1, 1, 0, 5'd1, 5'd4, 1, 5'd0, 0, 0, 0, 0, 3'd0, ec(1), "fl_rel");

        // LOAD_LAT=3: reset in the middle of a stall empties the line.
        doReset();
        applyStimulus(2, 1, 1, 1, 5'd4, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, ec(0), "mr_load");
        applyStimulus(2, 1, 1, 0, 5'd1, 5'd4, 1, 5'd0, 0, 0, 0, 1, 3'd0, ec(0), "mr_s0");
        applyStimulus(2, 0, 1, 0, 5'd1, 5'd4, 1, 5'd0, 0, 0, 0, 1, 3'd1, ec(1), "mr_rst");
        applyStimulus(2, 1, 1, 0, 5'd1, 5'd4, 1, 5'd0, 0, 0, 0, 0, 3'd0, ec(0), "mr_after");
        applyStimulus(2, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, ec(0), "mr_idle");

        // Let the monitor drain the queue and print the summary. The guard
        // catches a monitor that never gets there.
        end_req = 1'b1;
        repeat (50) @(posedge clk);
        $display("[TB] FAIL summary_timeout: got no summary expected summary");
        $fatal(1, "[TB] monitor did not finish");
    end

endmodule
